mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequences a single shared instruction/data memory port between the fetch stage (IF) and the memory stage (MEM) of the rv32i pipeline. The block runs a grant/transfer FSM against a ready/valid memory bus and generates the stall and bubble controls for the pipeline registers, including the Mem/WB register, while a transfer is outstanding. It also aborts transfers that time out. It sits beside the hazard unit and drives the enable/clear inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB flip-flop stages.

## Interface
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, maximum cycles waiting for bus_ready before abort (≥1)
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- if_req  in  1  fetch requests a read (level, held until if_done)
- if_addr  in  AW  fetch address
- if_done  out  1  one-cycle pulse: fetch transfer finished
- if_rdata  out  DW  fetched word, valid while if_done=1 and held after
- mem_req  in  1  MEM stage requests a load/store (level)
- mem_we  in  1  1=store
- mem_addr  in  AW  data address
- mem_wdata  in  DW  store data
- mem_be  in  4  byte enables
- mem_done  out  1  one-cycle pulse: data transfer finished
- mem_rdata  out  DW  load word, valid with mem_done and held after
- xfer_err  out  1  pulses with if_done/mem_done when the transfer timed out
- bus_valid, bus_we  out  1  bus request / write
- bus_addr  out  AW; bus_wdata  out  DW; bus_be  out  4
- bus_ready  in  1  transfer accepted/completed this cycle
- bus_rdata  in  DW  read data, valid when bus_valid && bus_ready
- stall_F, stall_D, stall_E, stall_M  out  1  hold the corresponding pipeline register
- flush_D, flush_W  out  1  insert a bubble into IF/ID and MEM/WB (clears RegWrite/ResultSrc)

## Operation
- FSM states: IDLE, IF_BUSY, MEM_BUSY.
- In IDLE, requests are eligible except a requester whose done is 1 this cycle.
  - Only one requester eligible: grant it.
  - Both eligible: grant MEM unless the last grant was MEM, in which case grant IF (alternating priority). last_grant resets to IF, so MEM wins the first tie.
- On grant, the request fields (addr, we, wdata, be) are latched into registers. The next state is the matching BUSY state.
- In BUSY: bus_valid=1, and bus_* are driven from the latched registers, stable until completion. IF transfers drive bus_we=0 and bus_be=4'hF.
- Completion on bus_valid && bus_ready:
  - For reads, bus_rdata is captured into if_rdata or mem_rdata. Writes leave mem_rdata unchanged.
  - The next state is IDLE, and the requester's done pulses high in that IDLE cycle.
- Timeout counter:
  - Clears on entering BUSY and increments each BUSY cycle without bus_ready.
  - When it reaches TIMEOUT, the transfer aborts: the FSM goes to IDLE, done and xfer_err pulse together, and rdata is not updated.
- Pipeline controls are combinational from state and inputs:
  - stall_M = mem_req && !mem_done.
  - stall_E = stall_D = stall_M || (if_req && !if_done).
  - stall_F = stall_D.
  - flush_W = stall_M.
  - flush_D = (if_req && !if_done) && !stall_M.
- Requesters must not change addr/data while their req is high and done has not yet pulsed. The block does not rely on this, because the fields are latched at grant.

## Timing
- Reset values, for reset=0 at a rising edge:
  - state=IDLE, last_grant=IF, counter=0.
  - bus_valid=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0.
  - if_done=0, mem_done=0, xfer_err=0, if_rdata=0, mem_rdata=0.
- Reset mid-transfer drops bus_valid the next cycle. No done pulse is generated and the request is forgotten.
- Minimum latency with bus_ready tied 1:
  - req seen in IDLE at cycle 0.
  - bus_valid at cycle 1, with completion in the same cycle.
  - done at cycle 2.
  - The next grant can occur at cycle 2 for the other requester, or at cycle 3 for the same requester.
- Each bus_ready stall adds one cycle. Timeout abort happens on the TIMEOUT-th BUSY cycle without ready, and done follows one cycle later.
- done is never high for more than one consecutive cycle per transfer. if_done and mem_done are never high together.
- bus_ready while bus_valid=0 is ignored.

## Test plan
- Single fetch, ready=1: if_req=1 at addr 0x100, bus_rdata=0x00500093 → bus_valid only in cycle 1 with addr 0x100; if_done=1 and if_rdata=0x00500093 in cycle 2; stall_F=1 in cycles 0–1 only.
- Store with wait states: mem_req, we=1, addr 0x2000, wdata 0xDEADBEEF, be=4'b0011, ready asserted after 3 cycles → bus fields stable for 4 BUSY cycles; mem_done=1 in the following cycle; mem_rdata unchanged; flush_W=1 throughout the stall.
- Simultaneous requests held continuously for 6 transfers → grants alternate MEM, IF, MEM, IF… from reset; no double done; no starvation.
- Timeout with TIMEOUT=4, ready=0 → exactly 4 BUSY cycles, then mem_done=1 and xfer_err=1 together, mem_rdata unchanged, FSM back in IDLE.
- Reset (reset=0) in the 2nd BUSY cycle of a load → next cycle bus_valid=0, all outputs at reset values, no done pulse; after release, a new request completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data-stage, memory-bus and pipeline-control signals around the shared memory port.
// The master modport is the arbiter side; the slave modport is the pipeline/memory side.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_done;
  logic [DW-1:0] if_rdata;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_done;
  logic [DW-1:0] mem_rdata;
  logic          xfer_err;

  logic          bus_valid;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [3:0]    bus_be;
  logic          bus_ready;
  logic [DW-1:0] bus_rdata;

  logic          stall_F;
  logic          stall_D;
  logic          stall_E;
  logic          stall_M;
  logic          flush_D;
  logic          flush_W;

  modport master (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           bus_ready, bus_rdata,
    output if_done, if_rdata, mem_done, mem_rdata, xfer_err,
           bus_valid, bus_we, bus_addr, bus_wdata, bus_be,
           stall_F, stall_D, stall_E, stall_M, flush_D, flush_W
  );

  modport slave (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           bus_ready, bus_rdata,
    input  if_done, if_rdata, mem_done, mem_rdata, xfer_err,
           bus_valid, bus_we, bus_addr, bus_wdata, bus_be,
           stall_F, stall_D, stall_E, stall_M, flush_D, flush_W
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and MEM stage, with alternating tie priority and timeout abort.
// Latency: grant 1 cycle after req, done 1 cycle after bus_ready; bus_ready low holds the transfer up to TIMEOUT cycles.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.master  p
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY} state_t;

  state_t        state_q, state_d;
  logic          last_mem_q, last_mem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic          if_done_q, if_done_d;
  logic          mem_done_q, mem_done_d;
  logic          err_q, err_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] mem_rdata_q, mem_rdata_d;

  logic if_elig, mem_elig, grant_mem, grant_if;
  logic if_wait, mem_wait;

  // A requester whose done is pulsing is finishing, not asking again.
  assign if_elig   = p.if_req  && !if_done_q;
  assign mem_elig  = p.mem_req && !mem_done_q;
  assign grant_mem = mem_elig && (!if_elig || !last_mem_q);
  assign grant_if  = if_elig && !grant_mem;

  always_comb begin
    state_d     = state_q;
    last_mem_d  = last_mem_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    err_d       = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_mem) begin
          state_d    = MEM_BUSY;
          last_mem_d = 1'b1;
          cnt_d      = '0;
          addr_d     = p.mem_addr;
          we_d       = p.mem_we;
          wdata_d    = p.mem_wdata;
          be_d       = p.mem_be;
        end else if (grant_if) begin
          state_d    = IF_BUSY;
          last_mem_d = 1'b0;
          cnt_d      = '0;
          addr_d     = p.if_addr;
          we_d       = 1'b0;
          wdata_d    = '0;
          be_d       = 4'hF;
        end
      end

      IF_BUSY, MEM_BUSY: begin
        if (p.bus_ready) begin
          state_d = IDLE;
          if (state_q == IF_BUSY) begin
            if_done_d  = 1'b1;
            if_rdata_d = p.bus_rdata;
          end else begin
            mem_done_d = 1'b1;
            if (!we_q) mem_rdata_d = p.bus_rdata;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Abort: report done with error, leave read data untouched.
          state_d    = IDLE;
          err_d      = 1'b1;
          if_done_d  = (state_q == IF_BUSY);
          mem_done_d = (state_q == MEM_BUSY);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_mem_q  <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      be_q        <= 4'h0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_mem_q  <= last_mem_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      err_q       <= err_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign p.bus_valid = (state_q != IDLE);
  assign p.bus_we    = we_q;
  assign p.bus_addr  = addr_q;
  assign p.bus_wdata = wdata_q;
  assign p.bus_be    = be_q;

  assign p.if_done   = if_done_q;
  assign p.mem_done  = mem_done_q;
  assign p.xfer_err  = err_q;
  assign p.if_rdata  = if_rdata_q;
  assign p.mem_rdata = mem_rdata_q;

  assign mem_wait  = p.mem_req && !mem_done_q;
  assign if_wait   = p.if_req  && !if_done_q;
  assign p.stall_M = mem_wait;
  assign p.stall_E = mem_wait || if_wait;
  assign p.stall_D = mem_wait || if_wait;
  assign p.stall_F = mem_wait || if_wait;
  assign p.flush_W = mem_wait;
  assign p.flush_D = if_wait && !mem_wait;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed reset/alternation sequences, random traffic vs. a reference model.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus_if ();
  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .p     (bus_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        ifr, mr, we, rdy;
    logic [31:0] rdat;
    logic        e_vld, e_ifd, e_md, e_err, e_stF, e_flD, e_flW;
    logic [31:0] e_addr;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_ifrd, e_mrd;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic addv(input logic ifr, mr, we, rdy, input logic [31:0] rdat,
                      input logic ev, eifd, emd, eerr, estf, efld, eflw,
                      input logic [31:0] eaddr, input logic ewe, input logic [3:0] ebe,
                      input logic [31:0] eifrd, emrd);
    vec_t v;
    v.ifr = ifr; v.mr = mr; v.we = we; v.rdy = rdy; v.rdat = rdat;
    v.e_vld = ev; v.e_ifd = eifd; v.e_md = emd; v.e_err = eerr;
    v.e_stF = estf; v.e_flD = efld; v.e_flW = eflw;
    v.e_addr = eaddr; v.e_we = ewe; v.e_be = ebe; v.e_ifrd = eifrd; v.e_mrd = emrd;
    tbl.push_back(v);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " bus_valid"}, bus_if.bus_valid, 0);
    chk({tag, " bus_we"},    bus_if.bus_we, 0);
    chk({tag, " bus_addr"},  bus_if.bus_addr, 0);
    chk({tag, " bus_wdata"}, bus_if.bus_wdata, 0);
    chk({tag, " bus_be"},    bus_if.bus_be, 0);
    chk({tag, " if_done"},   bus_if.if_done, 0);
    chk({tag, " mem_done"},  bus_if.mem_done, 0);
    chk({tag, " xfer_err"},  bus_if.xfer_err, 0);
    chk({tag, " if_rdata"},  bus_if.if_rdata, 0);
    chk({tag, " mem_rdata"}, bus_if.mem_rdata, 0);
  endtask

  task automatic idle_inputs();
    bus_if.if_req = 0; bus_if.if_addr = 0;
    bus_if.mem_req = 0; bus_if.mem_we = 0; bus_if.mem_addr = 0;
    bus_if.mem_wdata = 0; bus_if.mem_be = 0;
    bus_if.bus_ready = 0; bus_if.bus_rdata = 0;
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset just released.
  task automatic apply_reset(input string tag);
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals(tag);
    reset = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  // Reference model state for the random phase
  logic        m_busy, m_mem, m_we, m_last_mem;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  int          m_wait;
  logic        pd_if, pd_mem, pd_err;
  logic [31:0] e_ifrd, e_mrd;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   seen;
    logic order[6];
    int   both_done, dbl_done;
    logic prev_ifd, prev_md;
    int   lat;
    logic got;

    apply_reset("reset");

    // Fetch at 0x100, store at 0x2000 with 3 wait states, load that times out
    addv(1,0,0,1,32'h00500093, 0,0,0,0,1,1,0, 32'h0,0,4'h0,    32'h0,0);
    addv(1,0,0,1,32'h00500093, 1,0,0,0,1,1,0, 32'h100,0,4'hF,  32'h0,0);
    addv(1,0,0,1,32'h00500093, 0,1,0,0,0,0,0, 32'h0,0,4'h0,    32'h00500093,0);
    addv(0,0,0,1,32'h0,        0,0,0,0,0,0,0, 32'h0,0,4'h0,    32'h00500093,0);
    addv(0,1,1,0,32'h0,        0,0,0,0,1,0,1, 32'h0,0,4'h0,    32'h00500093,0);
    for (int k = 0; k < 3; k++)
      addv(0,1,1,0,32'hFFFFFFFF, 1,0,0,0,1,0,1, 32'h2000,1,4'h3, 32'h00500093,0);
    addv(0,1,1,1,32'hFFFFFFFF, 1,0,0,0,1,0,1, 32'h2000,1,4'h3, 32'h00500093,0);
    addv(0,1,1,1,32'h0,        0,0,1,0,0,0,0, 32'h0,0,4'h0,    32'h00500093,0);
    addv(0,0,0,1,32'h0,        0,0,0,0,0,0,0, 32'h0,0,4'h0,    32'h00500093,0);
    addv(0,1,0,0,32'hCAFEF00D, 0,0,0,0,1,0,1, 32'h0,0,4'h0,    32'h00500093,0);
    for (int k = 0; k < 4; k++)
      addv(0,1,0,0,32'hCAFEF00D, 1,0,0,0,1,0,1, 32'h2000,0,4'h3, 32'h00500093,0);
    addv(0,1,0,0,32'hCAFEF00D, 0,0,1,1,0,0,0, 32'h0,0,4'h0,    32'h00500093,0);
    addv(0,0,0,0,32'h0,        0,0,0,0,0,0,0, 32'h0,0,4'h0,    32'h00500093,0);

    bus_if.if_addr = 32'h100; bus_if.mem_addr = 32'h2000;
    bus_if.mem_wdata = 32'hDEADBEEF; bus_if.mem_be = 4'h3;
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      bus_if.if_req = v.ifr; bus_if.mem_req = v.mr; bus_if.mem_we = v.we;
      bus_if.bus_ready = v.rdy; bus_if.bus_rdata = v.rdat;
      #3;
      chk($sformatf("row%0d bus_valid", i), bus_if.bus_valid, v.e_vld);
      chk($sformatf("row%0d if_done", i),   bus_if.if_done, v.e_ifd);
      chk($sformatf("row%0d mem_done", i),  bus_if.mem_done, v.e_md);
      chk($sformatf("row%0d xfer_err", i),  bus_if.xfer_err, v.e_err);
      chk($sformatf("row%0d stall_F", i),   bus_if.stall_F, v.e_stF);
      chk($sformatf("row%0d stall_D", i),   bus_if.stall_D, v.e_stF);
      chk($sformatf("row%0d stall_E", i),   bus_if.stall_E, v.e_stF);
      chk($sformatf("row%0d stall_M", i),   bus_if.stall_M, v.e_flW);
      chk($sformatf("row%0d flush_D", i),   bus_if.flush_D, v.e_flD);
      chk($sformatf("row%0d flush_W", i),   bus_if.flush_W, v.e_flW);
      chk($sformatf("row%0d if_rdata", i),  bus_if.if_rdata, v.e_ifrd);
      chk($sformatf("row%0d mem_rdata", i), bus_if.mem_rdata, v.e_mrd);
      if (v.e_vld) begin
        chk($sformatf("row%0d bus_addr", i), bus_if.bus_addr, v.e_addr);
        chk($sformatf("row%0d bus_we", i),   bus_if.bus_we, v.e_we);
        chk($sformatf("row%0d bus_be", i),   bus_if.bus_be, v.e_be);
        if (v.e_we) chk($sformatf("row%0d bus_wdata", i), bus_if.bus_wdata, 32'hDEADBEEF);
      end
      next_cycle();
    end

    // Reset in the 2nd BUSY cycle of a load
    apply_reset("rst2");
    bus_if.mem_req = 1; bus_if.mem_we = 0; bus_if.mem_addr = 32'h44; bus_if.mem_be = 4'hF;
    bus_if.bus_ready = 0; bus_if.bus_rdata = 32'h11112222;
    next_cycle();
    #3 chk("midrst busy1 bus_valid", bus_if.bus_valid, 1);
    next_cycle();
    reset = 0;
    #3 chk("midrst busy2 bus_valid", bus_if.bus_valid, 1);
    next_cycle();
    reset = 1; bus_if.mem_req = 0;
    #3 check_reset_vals("midrst");
    got = 0;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      #3 if (bus_if.mem_done || bus_if.bus_valid) got = 1;
    end
    chk("midrst no done/valid after reset", got, 0);
    next_cycle();
    bus_if.if_req = 1; bus_if.if_addr = 32'h300;
    bus_if.bus_ready = 1; bus_if.bus_rdata = 32'h12345678;
    lat = -1;
    for (int k = 0; k < 10 && lat < 0; k++) begin
      #3 if (bus_if.if_done) lat = k;
      next_cycle();
    end
    chk("postrst fetch latency", lat, 2);
    chk("postrst if_rdata", bus_if.if_rdata, 32'h12345678);
    bus_if.if_req = 0;
    next_cycle();

    // Both requesters held: grants must alternate MEM, IF, ... from reset
    apply_reset("alt");
    bus_if.if_req = 1; bus_if.if_addr = 32'h400;
    bus_if.mem_req = 1; bus_if.mem_we = 0; bus_if.mem_addr = 32'h800; bus_if.mem_be = 4'hF;
    bus_if.bus_ready = 1; bus_if.bus_rdata = 32'h0;
    seen = 0; both_done = 0; dbl_done = 0; prev_ifd = 0; prev_md = 0;
    for (int k = 0; k < 40 && seen < 6; k++) begin
      #3;
      if (bus_if.bus_valid && bus_if.bus_ready) begin
        order[seen] = (bus_if.bus_addr == 32'h800);
        seen++;
      end
      if (bus_if.if_done && bus_if.mem_done) both_done++;
      if ((bus_if.if_done && prev_ifd) || (bus_if.mem_done && prev_md)) dbl_done++;
      prev_ifd = bus_if.if_done; prev_md = bus_if.mem_done;
      next_cycle();
    end
    chk("alt transfer count", seen, 6);
    for (int k = 0; k < 6; k++) chk($sformatf("alt grant%0d is_mem", k), order[k], (k % 2 == 0));
    chk("alt simultaneous done", both_done, 0);
    chk("alt repeated done", dbl_done, 0);
    bus_if.if_req = 0; bus_if.mem_req = 0;
    next_cycle();

    // Random traffic against the reference model
    apply_reset("rand");
    m_busy = 0; m_mem = 0; m_we = 0; m_last_mem = 0; m_addr = 0; m_wdata = 0; m_be = 0; m_wait = 0;
    pd_if = 0; pd_mem = 0; pd_err = 0; e_ifrd = 0; e_mrd = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic stingy, n_if, n_mem, n_err, el_if, el_mem;
      stingy = ((cyc / 150) % 2) == 1;
      if (!bus_if.if_req || pd_if) begin
        bus_if.if_req = ($urandom % 3) == 0;
        bus_if.if_addr = {$urandom_range(0, 32'h3FFF), 2'b00};
      end
      if (!bus_if.mem_req || pd_mem) begin
        bus_if.mem_req = ($urandom % 3) == 0;
        bus_if.mem_we = $urandom % 2;
        bus_if.mem_addr = $urandom;
        bus_if.mem_wdata = $urandom;
        bus_if.mem_be = $urandom % 16;
      end
      bus_if.bus_ready = stingy ? (($urandom % 8) == 0) : (($urandom % 4) != 0);
      bus_if.bus_rdata = mem_model(bus_if.bus_addr);
      #3;
      chk("rand if_done", bus_if.if_done, pd_if);
      chk("rand mem_done", bus_if.mem_done, pd_mem);
      chk("rand xfer_err", bus_if.xfer_err, pd_err);
      chk("rand if_rdata", bus_if.if_rdata, e_ifrd);
      chk("rand mem_rdata", bus_if.mem_rdata, e_mrd);
      chk("rand stall_F", bus_if.stall_F, (bus_if.mem_req && !pd_mem) || (bus_if.if_req && !pd_if));
      chk("rand stall_M", bus_if.stall_M, bus_if.mem_req && !pd_mem);
      chk("rand flush_D", bus_if.flush_D, (bus_if.if_req && !pd_if) && !(bus_if.mem_req && !pd_mem));
      chk("rand bus_valid", bus_if.bus_valid, m_busy);
      if (m_busy) begin
        chk("rand bus_addr", bus_if.bus_addr, m_addr);
        chk("rand bus_we", bus_if.bus_we, m_we);
        chk("rand bus_be", bus_if.bus_be, m_be);
        if (m_we) chk("rand bus_wdata", bus_if.bus_wdata, m_wdata);
      end
      n_if = 0; n_mem = 0; n_err = 0;
      if (m_busy) begin
        if (bus_if.bus_ready) begin
          if (!m_mem) e_ifrd = mem_model(m_addr);
          else if (!m_we) e_mrd = mem_model(m_addr);
          n_if = !m_mem; n_mem = m_mem; m_busy = 0;
        end else begin
          m_wait++;
          if (m_wait == TO) begin
            n_if = !m_mem; n_mem = m_mem; n_err = 1; m_busy = 0;
          end
        end
      end else begin
        el_if  = bus_if.if_req && !pd_if;
        el_mem = bus_if.mem_req && !pd_mem;
        if (el_if || el_mem) begin
          m_mem  = el_mem && !(el_if && m_last_mem);
          m_last_mem = m_mem;
          m_busy = 1; m_wait = 0;
          m_addr  = m_mem ? bus_if.mem_addr : bus_if.if_addr;
          m_we    = m_mem ? bus_if.mem_we : 1'b0;
          m_wdata = bus_if.mem_wdata;
          m_be    = m_mem ? bus_if.mem_be : 4'hF;
        end
      end
      pd_if = n_if; pd_mem = n_mem; pd_err = n_err;
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
